// File: rtl/stepdir_pkg.sv
// Shared definitions for the stepdir scheduler: move-word layout and FSM state encoding.
package stepdir_pkg;

  localparam int MOVE_WORD_W  = 72;

  localparam int ADD_LSB      = 0;
  localparam int ADD_W        = 20;
  localparam int COUNT_LSB    = ADD_LSB + ADD_W;
  localparam int COUNT_W      = 26;
  localparam int INTERVAL_LSB = COUNT_LSB + COUNT_W;
  localparam int INTERVAL_W   = 22;
  localparam int DIR_LSB      = INTERVAL_LSB + INTERVAL_W;
  localparam int DIR_W        = 1;
  localparam int TYPE_LSB     = DIR_LSB + DIR_W;
  localparam int TYPE_W       = 3;

  typedef struct packed {
    logic [TYPE_W-1:0]     mtype;
    logic                  dir;
    logic [INTERVAL_W-1:0] interval;
    logic [COUNT_W-1:0]    count;
    logic [ADD_W-1:0]      add;
  } move_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

endpackage

// File: rtl/stepdir_credit.sv
// Per-axis queue credit: saturating up/down count of words sitting in one stepdir queue.
module stepdir_credit #(
  parameter int MOVE_COUNT = 512,
  localparam int CW = $clog2(MOVE_COUNT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;

  assign full  = (credit_q == CW'(MOVE_COUNT));
  assign empty = (credit_q == '0);

  // Simultaneous push and pop cancel; a pop against an empty count is ignored.
  always_comb begin
    credit_d = credit_q;
    if (clr) begin
      credit_d = '0;
    end else if (inc && !dec && !full) begin
      credit_d = credit_q + CW'(1);
    end else if (dec && !inc && !empty) begin
      credit_d = credit_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/stepdir_sched.sv
// Steers host move words into per-axis stepdir queues, starts a set of axes together at a
// programmed timestamp, supervises the run and aborts on request.
module stepdir_sched
  import stepdir_pkg::*;
#(
  parameter int NUM_AXES   = 4,
  parameter int AXIS_W     = 2,
  parameter int MOVE_COUNT = 512,
  parameter int TIME_BITS  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AXIS_W-1:0]      cmd_axis,
  input  logic [MOVE_WORD_W-1:0] cmd_data,
  input  logic                   arm_valid,
  output logic                   arm_ready,
  input  logic [TIME_BITS-1:0]   arm_time,
  input  logic [NUM_AXES-1:0]    arm_mask,
  input  logic                   abort,
  input  logic                   err_clr,
  output logic [TIME_BITS-1:0]   now,
  output logic [MOVE_WORD_W-1:0] sd_wr_data,
  output logic [NUM_AXES-1:0]    sd_wr_en,
  output logic [NUM_AXES-1:0]    sd_start,
  output logic [NUM_AXES-1:0]    sd_reset,
  input  logic [NUM_AXES-1:0]    sd_pop,
  input  logic [NUM_AXES-1:0]    sd_running,
  input  logic [NUM_AXES-1:0]    sd_empty,
  output logic [1:0]             state,
  output logic                   done,
  output logic                   err_late,
  output logic [NUM_AXES-1:0]    err_underrun
);

  state_t                 state_q, state_d;
  logic                   abort_cnt_q, abort_cnt_d;
  logic                   alive_q, alive_d;
  logic [TIME_BITS-1:0]   now_q, now_d;
  logic [TIME_BITS-1:0]   arm_time_q, arm_time_d;
  logic [NUM_AXES-1:0]    mask_q, mask_d;
  logic                   idle_seen_q, idle_seen_d;
  logic                   done_q, done_d;
  logic [MOVE_WORD_W-1:0] wr_data_q, wr_data_d;
  logic [NUM_AXES-1:0]    wr_en_q, wr_en_d;
  logic                   err_late_q, err_late_d;
  logic [NUM_AXES-1:0]    err_underrun_q, err_underrun_d;

  logic [NUM_AXES-1:0]    axis_sel;
  logic [NUM_AXES-1:0]    credit_full;
  logic [NUM_AXES-1:0]    credit_zero;
  logic [NUM_AXES-1:0]    credit_inc;
  logic [NUM_AXES-1:0]    axis_quiet;
  logic [NUM_AXES-1:0]    underrun_ev;
  logic                   credit_clr;
  logic                   cmd_acc;
  logic                   arm_fire;
  logic                   reached;
  logic                   late_on_arm;
  logic                   all_quiet;
  logic [TIME_BITS-1:0]   diff_armed;
  logic [TIME_BITS-1:0]   diff_arm;

  // Decoding the axis one-hot also rejects out-of-range axis numbers for free.
  assign cmd_ready  = alive_q && !abort && (state_q != ST_ABORT) &&
                      (|axis_sel) && !(|(axis_sel & credit_full));
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign credit_clr = abort || (state_q == ST_ABORT);
  assign arm_fire   = arm_valid && arm_ready;

  // Sign of the difference makes the timestamp compare safe across timebase wrap.
  assign diff_armed  = now_q - arm_time_q;
  assign diff_arm    = now_q - arm_time;
  assign reached     = !diff_armed[TIME_BITS-1];
  assign late_on_arm = !diff_arm[TIME_BITS-1];
  assign all_quiet   = &axis_quiet;

  for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
    assign axis_sel[gi]   = (cmd_axis == AXIS_W'(gi));
    assign credit_inc[gi] = cmd_acc && axis_sel[gi];
    assign axis_quiet[gi] = !mask_q[gi] ||
                            (!sd_running[gi] && sd_empty[gi] && credit_zero[gi]);
    assign underrun_ev[gi] = (state_q == ST_RUN) && mask_q[gi] && !sd_running[gi] &&
                             (|(mask_q & sd_running & ~(NUM_AXES'(1) << gi)));

    stepdir_credit #(
      .MOVE_COUNT (MOVE_COUNT)
    ) u_credit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (credit_clr),
      .inc     (credit_inc[gi]),
      .dec     (sd_pop[gi]),
      .full    (credit_full[gi]),
      .empty   (credit_zero[gi])
    );
  end

  // Next-state logic; abort overrides every state.
  always_comb begin
    state_d     = state_q;
    abort_cnt_d = 1'b0;
    if (abort) begin
      state_d = ST_ABORT;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (arm_fire && (arm_mask != '0)) state_d = ST_ARMED;
        ST_ARMED: if (reached) state_d = ST_RUN;
        ST_RUN:   if (all_quiet && idle_seen_q) state_d = ST_IDLE;
        ST_ABORT: begin
          abort_cnt_d = 1'b1;
          if (abort_cnt_q) state_d = ST_IDLE;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    arm_ready = alive_q && (state_q == ST_IDLE);
    sd_start  = '0;
    sd_reset  = '0;
    if (state_q == ST_ARMED && reached && !abort) sd_start = mask_q;
    if (state_q == ST_ABORT) sd_reset = '1;
  end

  always_comb begin
    alive_d    = 1'b1;
    now_d      = now_q + TIME_BITS'(1);
    mask_d     = mask_q;
    arm_time_d = arm_time_q;
    if (abort) begin
      mask_d = '0;
    end else if (arm_fire) begin
      mask_d     = arm_mask;
      arm_time_d = arm_time;
    end

    // Completion must hold on two consecutive cycles to cover the stepdir pop latency.
    idle_seen_d = !abort && (state_q == ST_RUN) && all_quiet;
    done_d      = !abort && (state_q == ST_RUN) && all_quiet && idle_seen_q;

    wr_en_d   = cmd_acc ? axis_sel : '0;
    wr_data_d = cmd_acc ? cmd_data : wr_data_q;

    err_late_d     = (arm_fire && !abort && (arm_mask != '0) && late_on_arm) ||
                     (err_late_q && !err_clr);
    err_underrun_d = underrun_ev | (err_underrun_q & ~{NUM_AXES{err_clr}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      abort_cnt_q    <= 1'b0;
      alive_q        <= 1'b0;
      now_q          <= '0;
      arm_time_q     <= '0;
      mask_q         <= '0;
      idle_seen_q    <= 1'b0;
      done_q         <= 1'b0;
      wr_data_q      <= '0;
      wr_en_q        <= '0;
      err_late_q     <= 1'b0;
      err_underrun_q <= '0;
    end else begin
      state_q        <= state_d;
      abort_cnt_q    <= abort_cnt_d;
      alive_q        <= alive_d;
      now_q          <= now_d;
      arm_time_q     <= arm_time_d;
      mask_q         <= mask_d;
      idle_seen_q    <= idle_seen_d;
      done_q         <= done_d;
      wr_data_q      <= wr_data_d;
      wr_en_q        <= wr_en_d;
      err_late_q     <= err_late_d;
      err_underrun_q <= err_underrun_d;
    end
  end

  assign now          = now_q;
  assign sd_wr_data   = wr_data_q;
  assign sd_wr_en     = wr_en_q;
  assign state        = state_q;
  assign done         = done_q;
  assign err_late     = err_late_q;
  assign err_underrun = err_underrun_q;

endmodule
